ysyx_23060025_mdu_ctrl: RTL
===========================

Name: ysyx_23060025_mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer that sits beside the execute stage's single-cycle ALU. It handles all eight RV32M operations.
- EX hands it latched operands through a valid/ready handshake, holds its own ready-go low while the unit is busy, and collects the result through a valid/ready handshake.
- The unit runs radix-2 iterations (shift-add multiply, restoring divide) under an FSM with an iteration counter.
- It resolves divide-by-zero and signed overflow early, without iterating.
- It honours pipeline flush.

Parameters:
DATA_LEN, 32, operand/result width; iteration count equals DATA_LEN.

Ports:
- clock  in  1  Single clock.
- reset  in  1  Asynchronous, active-high; the block uses one clock.
- req_valid_i  in  1  EX presents an M-extension operation.
- req_op_i  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src1_i  in  DATA_LEN  rs1 value.
- src2_i  in  DATA_LEN  rs2 value.
- flush_i  in  1  Flush (fence.i/redirect); kills any operation in flight.
- req_ready_o  out  1  Unit idle; a request is accepted when req_valid_i & req_ready_o & ~flush_i.
- res_valid_o  out  1  Result available.
- res_data_o  out  DATA_LEN  Result.
- res_ready_i  in  1  EX/LSU consumes the result.
- busy_o  out  1  State is not IDLE; EX uses it to deassert ready-go.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset values (async): state IDLE, counter 0, internal registers 0, res_valid_o 0, res_data_o 0, busy_o 0. req_ready_o = (state==IDLE), so it reads 1 out of reset.
- Accept (IDLE, handshake true):
  - Latch op and both operands; later changes on src*_i are ignored.
  - Compute absolute values per signedness. Signed operands: MUL family src1 for MULH/MULHSU, src2 for MULH only; DIV/REM both.
  - Record result sign: product sign = xor of operand signs; quotient sign = xor; remainder sign = dividend sign.
  - Load counter with DATA_LEN-1.
- Fast path (divide ops only, decided at accept):
  - src2==0: quotient = all ones, remainder = src1.
  - DIV/REM with src1==0x80000000 and src2==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Go directly to DONE; res_valid_o is high the cycle after the accept edge (latency 1).
- Normal path, IDLE->CALC:
  - CALC performs one iteration per cycle: multiply is a 2*DATA_LEN-bit shift-add; divide is restoring subtract-shift.
  - Counter decrements each cycle. When counter==0, the final iteration and sign fix-up (two's-complement negate if the sign flag is set) write res_data_o, and the state goes to DONE.
  - Total latency: res_valid_o high exactly DATA_LEN+1 cycles after the accept edge (33 for default).
- Result selection: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE:
  - res_valid_o=1; res_data_o is held stable until res_ready_i.
  - res_ready_i=1 -> IDLE next edge, res_valid_o 0.
  - No back-to-back issue: req_ready_o is 0 in DONE, so the earliest new accept is the cycle after the result is consumed.
- Flush:
  - flush_i in any state -> IDLE at next edge, res_valid_o 0, counter cleared. Any partial or completed result is discarded.
  - A request presented in the same cycle as flush_i is not accepted.
  - flush_i in DONE coincident with res_ready_i: flush wins; the consumer must treat the result as killed.
- Reset mid-CALC: the block returns immediately (asynchronously) to the reset values. After deassertion the next request behaves as from power-on.
- busy_o = (state!=IDLE). It is registered-state derived, with no combinational path from req_valid_i.

Decomposition:
- Shared define file: MDU op encodings (`MDU_OP_MUL ... `MDU_OP_REMU`), FSM state encodings (`MDU_IDLE/CALC/DONE`), and the div-overflow constant.
- Sub-module ysyx_23060025_mdu_iter: one combinational iteration step. Inputs are the accumulator/partial remainder, multiplicand/divisor and mode; outputs are the next accumulator and quotient bit. The controller owns all state, counter, sign fix-up and handshakes.

Test Plan:
- MUL: src1=7, src2=0xFFFFFFFD (-3), accepted at cycle 0 -> busy_o=1 cycles 1..33; res_valid_o rises at cycle 33 with res_data_o=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 0x00000007, both with res_valid_o at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; both at cycle 1.
- Signed rounding: DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14; REMU -> 2.
- Backpressure: hold res_ready_i=0 for 5 cycles after res_valid_o -> res_data_o stable, req_ready_o=0. Assert res_ready_i -> IDLE next cycle. A second request then accepts and completes correctly.
- Flush at CALC cycle 10 -> next cycle state IDLE, res_valid_o never asserts, req_ready_o=1. Async reset asserted mid-CALC -> all outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ysyx_23060025_mdu_ctrl_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// operation encodings (RISC-V funct3), FSM states, the signed
// divide-overflow dividend, and small operation-decode helpers.
package ysyx_23060025_mdu_ctrl_pkg;

   localparam int MDU_DATA_LEN = 32;

   // Most negative 32-bit value; divided by -1 it has no representable quotient.
   localparam logic [31:0] MDU_DIV_OVF_DVD = 32'h8000_0000;

   typedef enum logic [2:0] {
      MDU_OP_MUL    = 3'd0,
      MDU_OP_MULH   = 3'd1,
      MDU_OP_MULHSU = 3'd2,
      MDU_OP_MULHU  = 3'd3,
      MDU_OP_DIV    = 3'd4,
      MDU_OP_DIVU   = 3'd5,
      MDU_OP_REM    = 3'd6,
      MDU_OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_CALC = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_e;

   // Divide family (DIV/DIVU/REM/REMU) versus multiply family.
   function automatic logic op_is_div(input mdu_op_e op);
      logic r;
      case (op)
         MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_REM, MDU_OP_REMU: r = 1'b1;
         default:                                          r = 1'b0;
      endcase
      return r;
   endfunction

   // rs1 is interpreted as two's complement for these operations.
   function automatic logic op_src1_signed(input mdu_op_e op);
      logic r;
      case (op)
         MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_DIV, MDU_OP_REM: r = 1'b1;
         default:                                            r = 1'b0;
      endcase
      return r;
   endfunction

   // rs2 is interpreted as two's complement for these operations.
   function automatic logic op_src2_signed(input mdu_op_e op);
      logic r;
      case (op)
         MDU_OP_MULH, MDU_OP_DIV, MDU_OP_REM: r = 1'b1;
         default:                             r = 1'b0;
      endcase
      return r;
   endfunction

   // Operations whose result is the quotient rather than the remainder.
   function automatic logic op_is_quot(input mdu_op_e op);
      logic r;
      case (op)
         MDU_OP_DIV, MDU_OP_DIVU: r = 1'b1;
         default:                 r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ysyx_23060025_mdu_iter.sv
// One combinational radix-2 step of the multiply/divide datapath.
// Multiply: accumulator is {high partial product, remaining multiplier};
//   add the multiplicand when the multiplier LSB is set, then shift right.
// Divide: accumulator is {partial remainder, remaining dividend};
//   shift left one bit, trial-subtract the divisor, restore on borrow.
//   The quotient bit is returned separately; acc_next carries 0 in its LSB.
module ysyx_23060025_mdu_iter #(
   parameter int DATA_LEN = 32
) (
   input  logic [2*DATA_LEN-1:0] acc,
   input  logic [DATA_LEN-1:0]   operand,
   input  logic                  div_mode,
   output logic [2*DATA_LEN-1:0] acc_next,
   output logic                  q_bit
);

   logic [DATA_LEN:0] add_sum_s;
   logic [DATA_LEN:0] trial_s;
   logic [DATA_LEN:0] diff_s;
   logic              ge_s;

   // Single iteration for either mode.
   always_comb begin
      add_sum_s = {1'b0, acc[2*DATA_LEN-1:DATA_LEN]}
                + (acc[0] ? {1'b0, operand} : {(DATA_LEN+1){1'b0}});
      trial_s   = {acc[2*DATA_LEN-1:DATA_LEN], acc[DATA_LEN-1]};
      diff_s    = trial_s - {1'b0, operand};
      // Partial remainder stays below the divisor, so the difference MSB is the borrow.
      ge_s      = ~diff_s[DATA_LEN];
      if (div_mode) begin
         acc_next = {(ge_s ? diff_s[DATA_LEN-1:0] : trial_s[DATA_LEN-1:0]),
                     acc[DATA_LEN-2:0], 1'b0};
         q_bit    = ge_s;
      end else begin
         acc_next = {add_sum_s, acc[DATA_LEN-1:1]};
         q_bit    = 1'b0;
      end
   end

endmodule

// File: rtl/ysyx_23060025_mdu_ctrl.sv
// RV32M multi-cycle multiply/divide sequencer. Accepts one operation at a
// time from EX, iterates DATA_LEN radix-2 steps (or resolves divide-by-zero
// and signed overflow immediately), then holds the result until consumed.
// Operands are converted to magnitudes at accept and the sign is restored
// on the final iteration.
module ysyx_23060025_mdu_ctrl
   import ysyx_23060025_mdu_ctrl_pkg::*;
#(
   parameter int DATA_LEN = MDU_DATA_LEN
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid_i,
   input  logic [2:0]          req_op_i,
   input  logic [DATA_LEN-1:0] src1_i,
   input  logic [DATA_LEN-1:0] src2_i,
   input  logic                flush_i,
   output logic                req_ready_o,
   output logic                res_valid_o,
   output logic [DATA_LEN-1:0] res_data_o,
   input  logic                res_ready_i,
   output logic                busy_o
);

   localparam int CNT_W = $clog2(DATA_LEN);
   localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DATA_LEN - 1);
   localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_LEN-1:0]   ZERO_N   = {DATA_LEN{1'b0}};
   localparam logic [DATA_LEN-1:0]   ONES_N   = {DATA_LEN{1'b1}};
   localparam logic [DATA_LEN-1:0]   ONE_N    = {{(DATA_LEN-1){1'b0}}, 1'b1};
   localparam logic [2*DATA_LEN-1:0] ONE_2N   = {{(2*DATA_LEN-1){1'b0}}, 1'b1};
   // Width-generic form of MDU_DIV_OVF_DVD.
   localparam logic [DATA_LEN-1:0]   OVF_DVD  = {1'b1, {(DATA_LEN-1){1'b0}}};

   mdu_state_e            state_r;
   mdu_state_e            state_nxt_s;
   mdu_op_e               op_r;
   mdu_op_e               req_op_s;
   logic [2*DATA_LEN-1:0] acc_r;
   logic [DATA_LEN-1:0]   opnd_r;
   logic                  neg_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  res_valid_r;
   logic                  busy_r;
   logic                  req_ready_r;
   logic [DATA_LEN-1:0]   res_data_r;

   logic                  accept_s;
   logic                  is_div_s;
   logic                  sign1_s;
   logic                  sign2_s;
   logic [DATA_LEN-1:0]   abs1_s;
   logic [DATA_LEN-1:0]   abs2_s;
   logic                  neg_s;
   logic                  div_zero_s;
   logic                  div_ovf_s;
   logic                  fast_s;
   logic [DATA_LEN-1:0]   fast_data_s;

   logic [2*DATA_LEN-1:0] iter_acc_s;
   logic                  iter_q_s;
   logic [2*DATA_LEN-1:0] acc_nxt_s;
   logic [2*DATA_LEN-1:0] prod_s;
   logic [DATA_LEN-1:0]   quot_s;
   logic [DATA_LEN-1:0]   rem_s;
   logic [DATA_LEN-1:0]   calc_data_s;
   logic                  valid_nxt_s;
   logic                  busy_nxt_s;
   logic                  ready_nxt_s;

   ysyx_23060025_mdu_iter #(
      .DATA_LEN (DATA_LEN)
   ) u_iter (
      .acc      (acc_r),
      .operand  (opnd_r),
      .div_mode (op_is_div(op_r)),
      .acc_next (iter_acc_s),
      .q_bit    (iter_q_s)
   );

   // Request decode: handshake, operand magnitudes, result sign, early-out cases.
   always_comb begin
      req_op_s   = mdu_op_e'(req_op_i);
      accept_s   = req_valid_i & (state_r == MDU_IDLE) & ~flush_i;
      is_div_s   = op_is_div(req_op_s);
      sign1_s    = op_src1_signed(req_op_s) & src1_i[DATA_LEN-1];
      sign2_s    = op_src2_signed(req_op_s) & src2_i[DATA_LEN-1];
      abs1_s     = sign1_s ? (~src1_i + ONE_N) : src1_i;
      abs2_s     = sign2_s ? (~src2_i + ONE_N) : src2_i;
      div_zero_s = (src2_i == ZERO_N);
      div_ovf_s  = op_src2_signed(req_op_s) & (src1_i == OVF_DVD) & (src2_i == ONES_N);
      fast_s     = is_div_s & (div_zero_s | div_ovf_s);
      // Remainder takes the dividend's sign; product and quotient take the xor.
      if (is_div_s && !op_is_quot(req_op_s)) begin
         neg_s = sign1_s;
      end else begin
         neg_s = sign1_s ^ sign2_s;
      end
      if (op_is_quot(req_op_s)) begin
         fast_data_s = div_zero_s ? ONES_N : OVF_DVD;
      end else begin
         fast_data_s = div_zero_s ? src1_i : ZERO_N;
      end
   end

   // Final-iteration result: merge quotient bit, restore sign, select the half.
   always_comb begin
      acc_nxt_s = {iter_acc_s[2*DATA_LEN-1:1], iter_acc_s[0] | iter_q_s};
      prod_s    = neg_r ? (~acc_nxt_s + ONE_2N) : acc_nxt_s;
      quot_s    = neg_r ? (~acc_nxt_s[DATA_LEN-1:0] + ONE_N) : acc_nxt_s[DATA_LEN-1:0];
      rem_s     = neg_r ? (~acc_nxt_s[2*DATA_LEN-1:DATA_LEN] + ONE_N)
                        : acc_nxt_s[2*DATA_LEN-1:DATA_LEN];
      case (op_r)
         MDU_OP_MUL:                               calc_data_s = prod_s[DATA_LEN-1:0];
         MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU: calc_data_s = prod_s[2*DATA_LEN-1:DATA_LEN];
         MDU_OP_DIV, MDU_OP_DIVU:                  calc_data_s = quot_s;
         MDU_OP_REM, MDU_OP_REMU:                  calc_data_s = rem_s;
         default:                                  calc_data_s = ZERO_N;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= MDU_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state; flush overrides every transition.
   always_comb begin
      if (flush_i) begin
         state_nxt_s = MDU_IDLE;
      end else begin
         case (state_r)
            MDU_IDLE: begin
               if (accept_s) begin
                  state_nxt_s = fast_s ? MDU_DONE : MDU_CALC;
               end else begin
                  state_nxt_s = MDU_IDLE;
               end
            end
            MDU_CALC: begin
               if (cnt_r == CNT_ZERO) begin
                  state_nxt_s = MDU_DONE;
               end else begin
                  state_nxt_s = MDU_CALC;
               end
            end
            MDU_DONE: begin
               if (res_ready_i) begin
                  state_nxt_s = MDU_IDLE;
               end else begin
                  state_nxt_s = MDU_DONE;
               end
            end
            default: state_nxt_s = MDU_IDLE;
         endcase
      end
   end

   // FSM outputs, computed from the next state so the ports are flop-driven.
   always_comb begin
      valid_nxt_s = (state_nxt_s == MDU_DONE);
      busy_nxt_s  = (state_nxt_s != MDU_IDLE);
      ready_nxt_s = (state_nxt_s == MDU_IDLE);
   end

   // Output status registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         res_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         req_ready_r <= 1'b1;
      end else begin
         res_valid_r <= valid_nxt_s;
         busy_r      <= busy_nxt_s;
         req_ready_r <= ready_nxt_s;
      end
   end

   // Datapath: latch at accept, iterate in CALC, write the result on completion.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_r       <= MDU_OP_MUL;
         acc_r      <= {(2*DATA_LEN){1'b0}};
         opnd_r     <= ZERO_N;
         neg_r      <= 1'b0;
         cnt_r      <= CNT_ZERO;
         res_data_r <= ZERO_N;
      end else if (flush_i) begin
         cnt_r <= CNT_ZERO;
      end else begin
         case (state_r)
            MDU_IDLE: begin
               if (accept_s) begin
                  op_r  <= req_op_s;
                  neg_r <= neg_s;
                  cnt_r <= CNT_LOAD;
                  if (is_div_s) begin
                     acc_r  <= {ZERO_N, abs1_s};
                     opnd_r <= abs2_s;
                  end else begin
                     acc_r  <= {ZERO_N, abs2_s};
                     opnd_r <= abs1_s;
                  end
                  if (fast_s) begin
                     res_data_r <= fast_data_s;
                  end
               end
            end
            MDU_CALC: begin
               acc_r <= acc_nxt_s;
               if (cnt_r == CNT_ZERO) begin
                  res_data_r <= calc_data_s;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign req_ready_o = req_ready_r;
   assign res_valid_o = res_valid_r;
   assign res_data_o  = res_data_r;
   assign busy_o      = busy_r;

endmodule
